// File: rtl/classifier_topic_lookup_if.sv
// classifier_topic_lookup_if
// Request/result channel between the classifier pipeline and the topic
// lookup engine.
//   master : drives lkup_valid/lkup_key/lkup_hash0/lkup_hash1/cur_time,
//            receives lkup_ready/lkup_done/lkup_hit/lkup_expired/lkup_tid
//   slave  : the lookup engine side of the same signals
// Width macros fall back to local defaults when the including build does
// not provide them.

`ifndef TOPIC_HASH_TABLE_DEPTH_NBITS
`define TOPIC_HASH_TABLE_DEPTH_NBITS 10
`endif
`ifndef TOPIC_HASH_BUCKET_NBITS
`define TOPIC_HASH_BUCKET_NBITS 48
`endif
`ifndef TOPIC_VALUE_NBITS
`define TOPIC_VALUE_NBITS 32
`endif
`ifndef TOPIC_VALUE_DEPTH_NBITS
`define TOPIC_VALUE_DEPTH_NBITS 10
`endif
`ifndef TOPIC_KEY_NBITS
`define TOPIC_KEY_NBITS 16
`endif
`ifndef EXP_TIME_NBITS
`define EXP_TIME_NBITS 16
`endif

interface classifier_topic_lookup_if #(
  parameter int DEPTH_NBITS       = `TOPIC_HASH_TABLE_DEPTH_NBITS,
  parameter int VALUE_DEPTH_NBITS = `TOPIC_VALUE_DEPTH_NBITS,
  parameter int KEY_NBITS         = `TOPIC_KEY_NBITS,
  parameter int TIME_NBITS        = `EXP_TIME_NBITS
);
  logic                         lkup_valid;
  logic                         lkup_ready;
  logic [KEY_NBITS-1:0]         lkup_key;
  logic [DEPTH_NBITS-1:0]       lkup_hash0;
  logic [DEPTH_NBITS-1:0]       lkup_hash1;
  logic [TIME_NBITS-1:0]        cur_time;
  logic                         lkup_done;
  logic                         lkup_hit;
  logic                         lkup_expired;
  logic [VALUE_DEPTH_NBITS-1:0] lkup_tid;

  modport master (
    output lkup_valid, lkup_key, lkup_hash0, lkup_hash1, cur_time,
    input  lkup_ready, lkup_done, lkup_hit, lkup_expired, lkup_tid
  );

  modport slave (
    input  lkup_valid, lkup_key, lkup_hash0, lkup_hash1, cur_time,
    output lkup_ready, lkup_done, lkup_hit, lkup_expired, lkup_tid
  );
endinterface

// File: rtl/classifier_topic_lookup.sv
// classifier_topic_lookup
// Topic lookup engine: reads both buckets of the two-way topic hash table,
// walks the valid pointer slots (bucket0 slots 0..ENTRIES-1, then bucket1)
// against the topic key store and reports hit/miss/expired plus the topic ID.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   lkup (slave)        request (valid/ready, key, hash0/1, cur_time) and
//                       result (done strobe, hit, expired, tid)
//   topic_hash_table0/1 bucket read (rd/raddr out, ack/rdata in)
//   topic_key           key store read, ack one cycle after rd
//   topic_etime         expiry store read, ack one cycle after rd
// Optional feature macro: TOPIC_LOOKUP_ETIME_CHECK_EN enables the expiry
// read and lkup_expired; without it the etime port is tied off and
// lkup_expired is always 0, with identical timing.

`ifndef TOPIC_HASH_TABLE_DEPTH_NBITS
`define TOPIC_HASH_TABLE_DEPTH_NBITS 10
`endif
`ifndef TOPIC_HASH_BUCKET_NBITS
`define TOPIC_HASH_BUCKET_NBITS 48
`endif
`ifndef TOPIC_VALUE_NBITS
`define TOPIC_VALUE_NBITS 32
`endif
`ifndef TOPIC_VALUE_DEPTH_NBITS
`define TOPIC_VALUE_DEPTH_NBITS 10
`endif
`ifndef TOPIC_KEY_NBITS
`define TOPIC_KEY_NBITS 16
`endif
`ifndef EXP_TIME_NBITS
`define EXP_TIME_NBITS 16
`endif

module classifier_topic_lookup #(
  parameter int DEPTH_NBITS       = `TOPIC_HASH_TABLE_DEPTH_NBITS,
  parameter int BUCKET_NBITS      = `TOPIC_HASH_BUCKET_NBITS,
  parameter int VALUE_NBITS       = `TOPIC_VALUE_NBITS,
  parameter int VALUE_DEPTH_NBITS = `TOPIC_VALUE_DEPTH_NBITS,
  parameter int ENTRIES           = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  classifier_topic_lookup_if.slave     lkup,
  output logic                         topic_hash_table0_rd,
  output logic [DEPTH_NBITS-1:0]       topic_hash_table0_raddr,
  input  logic                         topic_hash_table0_ack,
  input  logic [BUCKET_NBITS-1:0]      topic_hash_table0_rdata,
  output logic                         topic_hash_table1_rd,
  output logic [DEPTH_NBITS-1:0]       topic_hash_table1_raddr,
  input  logic                         topic_hash_table1_ack,
  input  logic [BUCKET_NBITS-1:0]      topic_hash_table1_rdata,
  output logic                         topic_key_rd,
  output logic [VALUE_DEPTH_NBITS-1:0] topic_key_raddr,
  input  logic                         topic_key_ack,
  input  logic [VALUE_NBITS-1:0]       topic_key_rdata,
  output logic                         topic_etime_rd,
  output logic [VALUE_DEPTH_NBITS-1:0] topic_etime_raddr,
  input  logic                         topic_etime_ack,
  input  logic [`EXP_TIME_NBITS-1:0]   topic_etime_rdata
);
  localparam int KEY_NBITS  = `TOPIC_KEY_NBITS;
  localparam int TIME_NBITS = `EXP_TIME_NBITS;
  localparam int SLOT_NBITS = VALUE_DEPTH_NBITS + 1;
  localparam int CAND_NUM   = 2 * ENTRIES;
  localparam int CIDX_NBITS = $clog2(CAND_NUM);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HT_WAIT  = 3'd1,
    ST_SCAN     = 3'd2,
    ST_KEY_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t                       state_r;
  logic [KEY_NBITS-1:0]         key_r;
  logic [TIME_NBITS-1:0]        cur_time_r;
  logic [DEPTH_NBITS-1:0]       ht0_raddr_r;
  logic [DEPTH_NBITS-1:0]       ht1_raddr_r;
  logic                         ht_rd_r;
  logic                         ack0_seen_r;
  logic                         ack1_seen_r;
  logic [BUCKET_NBITS-1:0]      bucket0_r;
  logic [BUCKET_NBITS-1:0]      bucket1_r;
  logic [CAND_NUM-1:0]          scanned_r;
  logic [VALUE_DEPTH_NBITS-1:0] ptr_r;
  logic                         key_rd_r;
  logic                         ready_r;
  logic                         done_r;
  logic                         hit_r;
  logic                         expired_r;
  logic [VALUE_DEPTH_NBITS-1:0] tid_r;

  logic [CAND_NUM-1:0]          cand_valid_s;
  logic [VALUE_DEPTH_NBITS-1:0] cand_ptr_s [CAND_NUM];
  logic                         next_found_s;
  logic [CIDX_NBITS-1:0]        next_idx_s;
  logic                         key_match_s;
  logic                         expired_s;
  logic                         acks_done_s;
  logic                         unused_s;

  // Unpack both latched buckets into one ordered candidate list.
  always_comb begin
    cand_valid_s = '0;
    for (int i = 0; i < CAND_NUM; i++) begin
      cand_ptr_s[i] = '0;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      cand_valid_s[i]           = bucket0_r[i*SLOT_NBITS + VALUE_DEPTH_NBITS];
      cand_ptr_s[i]             = bucket0_r[i*SLOT_NBITS +: VALUE_DEPTH_NBITS];
      cand_valid_s[ENTRIES + i] = bucket1_r[i*SLOT_NBITS + VALUE_DEPTH_NBITS];
      cand_ptr_s[ENTRIES + i]   = bucket1_r[i*SLOT_NBITS +: VALUE_DEPTH_NBITS];
    end
  end

  // Lowest-numbered valid candidate not yet read; descending loop so the
  // earliest slot wins.
  always_comb begin
    next_found_s = 1'b0;
    next_idx_s   = '0;
    for (int i = CAND_NUM - 1; i >= 0; i--) begin
      if (cand_valid_s[i] && !scanned_r[i]) begin
        next_found_s = 1'b1;
        next_idx_s   = CIDX_NBITS'(i);
      end else begin
        next_found_s = next_found_s;
      end
    end
  end

  assign key_match_s = (topic_key_rdata[KEY_NBITS-1:0] == key_r);
  // The last outstanding bucket ack may arrive this cycle.
  assign acks_done_s = (ack0_seen_r | topic_hash_table0_ack) &
                       (ack1_seen_r | topic_hash_table1_ack);

`ifdef TOPIC_LOOKUP_ETIME_CHECK_EN
  // The etime store answers in the same cycle as the key store, so its
  // rdata is valid alongside topic_key_ack. Zero etime counts as expired.
  assign expired_s         = (topic_etime_rdata <= cur_time_r);
  assign topic_etime_rd    = key_rd_r;
  assign topic_etime_raddr = ptr_r;
`else
  assign expired_s         = 1'b0;
  assign topic_etime_rd    = 1'b0;
  assign topic_etime_raddr = '0;
`endif

  // Bits that are only partially consumed (key width, bucket padding,
  // etime port when the expiry check is compiled out).
  assign unused_s = ^{topic_etime_ack, topic_etime_rdata, topic_key_rdata,
                      bucket0_r, bucket1_r, cur_time_r};

  // Lookup FSM: accept, bucket fetch, candidate walk and result strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      key_r       <= '0;
      cur_time_r  <= '0;
      ht0_raddr_r <= '0;
      ht1_raddr_r <= '0;
      ht_rd_r     <= 1'b0;
      ack0_seen_r <= 1'b0;
      ack1_seen_r <= 1'b0;
      bucket0_r   <= '0;
      bucket1_r   <= '0;
      scanned_r   <= '0;
      ptr_r       <= '0;
      key_rd_r    <= 1'b0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      hit_r       <= 1'b0;
      expired_r   <= 1'b0;
      tid_r       <= '0;
    end else begin
      ht_rd_r  <= 1'b0;
      key_rd_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (lkup.lkup_valid && ready_r) begin
            ready_r     <= 1'b0;
            key_r       <= lkup.lkup_key;
            cur_time_r  <= lkup.cur_time;
            ht0_raddr_r <= lkup.lkup_hash0;
            ht1_raddr_r <= lkup.lkup_hash1;
            ht_rd_r     <= 1'b1;
            ack0_seen_r <= 1'b0;
            ack1_seen_r <= 1'b0;
            scanned_r   <= '0;
            hit_r       <= 1'b0;
            expired_r   <= 1'b0;
            tid_r       <= '0;
            state_r     <= ST_HT_WAIT;
          end
        end
        ST_HT_WAIT: begin
          if (topic_hash_table0_ack) begin
            ack0_seen_r <= 1'b1;
            bucket0_r   <= topic_hash_table0_rdata;
          end
          if (topic_hash_table1_ack) begin
            ack1_seen_r <= 1'b1;
            bucket1_r   <= topic_hash_table1_rdata;
          end
          if (acks_done_s) begin
            state_r <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (next_found_s) begin
            key_rd_r              <= 1'b1;
            ptr_r                 <= cand_ptr_s[next_idx_s];
            scanned_r[next_idx_s] <= 1'b1;
            state_r               <= ST_KEY_WAIT;
          end else begin
            // Empty candidate list: DONE raises the strobe one cycle later.
            state_r <= ST_DONE;
          end
        end
        ST_KEY_WAIT: begin
          if (topic_key_ack) begin
            if (key_match_s) begin
              hit_r     <= 1'b1;
              tid_r     <= ptr_r;
              expired_r <= expired_s;
              done_r    <= 1'b1;
              state_r   <= ST_DONE;
            end else if (next_found_s) begin
              // Chain straight into the next read so each mismatch costs
              // exactly two cycles.
              key_rd_r              <= 1'b1;
              ptr_r                 <= cand_ptr_s[next_idx_s];
              scanned_r[next_idx_s] <= 1'b1;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (done_r) begin
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
            hit_r     <= 1'b0;
            expired_r <= 1'b0;
            tid_r     <= '0;
            state_r   <= ST_IDLE;
          end else begin
            done_r <= 1'b1;
          end
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign topic_hash_table0_rd    = ht_rd_r;
  assign topic_hash_table1_rd    = ht_rd_r;
  assign topic_hash_table0_raddr = ht0_raddr_r;
  assign topic_hash_table1_raddr = ht1_raddr_r;
  assign topic_key_rd            = key_rd_r;
  assign topic_key_raddr         = ptr_r;
  assign lkup.lkup_ready         = ready_r;
  assign lkup.lkup_done          = done_r;
  assign lkup.lkup_hit           = hit_r;
  assign lkup.lkup_expired       = expired_r;
  assign lkup.lkup_tid           = tid_r;
endmodule

// File: doc/classifier_topic_lookup.md
# classifier_topic_lookup

Topic lookup engine for the classifier: takes a topic key plus its two precomputed hash indices, reads both buckets of the two-way topic hash table, walks the valid candidate pointers against the topic key store, and checks the expiry time of a matching entry. It sits directly downstream of `classifier_mem_topic`. It drives that block's `topic_hash_table0/1`, `topic_key` and `topic_etime` read ports and consumes their ack/rdata. It returns hit/miss/expired plus the topic ID to the classifier pipeline.

## Interface
Parameters:
- DEPTH_NBITS, `TOPIC_HASH_TABLE_DEPTH_NBITS, hash table index width
- BUCKET_NBITS, `TOPIC_HASH_BUCKET_NBITS, bucket width
- VALUE_NBITS, `TOPIC_VALUE_NBITS, key store read width
- VALUE_DEPTH_NBITS, `TOPIC_VALUE_DEPTH_NBITS, key/etime store index width (= TID width used here)
- ENTRIES, 4, pointer slots per bucket; entry i = bucket[i*(VALUE_DEPTH_NBITS+1) +: VALUE_DEPTH_NBITS+1], MSB = valid, rest = ptr; requires BUCKET_NBITS >= ENTRIES*(VALUE_DEPTH_NBITS+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- lkup_valid  in  1  request valid; held until accepted
- lkup_ready  out  1  engine idle; accept = lkup_valid & lkup_ready
- lkup_key  in  `TOPIC_KEY_NBITS  topic key
- lkup_hash0 / lkup_hash1  in  DEPTH_NBITS  bucket indices
- cur_time  in  `EXP_TIME_NBITS  current time, sampled at accept
- topic_hash_table0_rd / _raddr  out  1 / DEPTH_NBITS  bucket 0 read
- topic_hash_table0_ack / _rdata  in  1 / BUCKET_NBITS  bucket 0 return
- topic_hash_table1_rd / _raddr, topic_hash_table1_ack / _rdata  as above, bucket 1
- topic_key_rd / _raddr  out  1 / VALUE_DEPTH_NBITS  key store read
- topic_key_ack / _rdata  in  1 / VALUE_NBITS  key return
- topic_etime_rd / _raddr  out  1 / VALUE_DEPTH_NBITS  expiry read
- topic_etime_ack / _rdata  in  1 / `EXP_TIME_NBITS  expiry return
- lkup_done  out  1  one-cycle result strobe
- lkup_hit / lkup_expired  out  1 / 1  result flags, valid with lkup_done
- lkup_tid  out  VALUE_DEPTH_NBITS  matching pointer; 0 on miss

## Operation
- States: IDLE, HT_WAIT, SCAN, KEY_WAIT, DONE.
- IDLE: lkup_ready=1. On accept, latch key/hash0/hash1/cur_time and go to HT_WAIT.
- HT_WAIT: the first cycle pulses both hash_table rd for one cycle. The engine then collects both acks, which may arrive in any order, the same cycle, or with arbitrary delay (PIO sharing). Each rdata is latched on its ack. When both are held, go to SCAN.
- Candidate list: bucket0 entries 0..ENTRIES-1, then bucket1 entries 0..ENTRIES-1. Only valid slots are candidates. Duplicate ptrs are scanned twice (harmless).
- SCAN: if no unscanned valid candidate remains, go to DONE with a miss. Otherwise pulse topic_key_rd (and topic_etime_rd) with raddr = ptr, then go to KEY_WAIT.
- KEY_WAIT: on topic_key_ack, a match is topic_key_rdata[`TOPIC_KEY_NBITS-1:0] == latched key.
  - Match: go to DONE with hit=1, tid=ptr, expired = (etime_rdata <= latched cur_time), unsigned, no wrap. A zero etime (init value) is therefore expired.
  - No match: return to SCAN and take the next candidate.
- DONE: pulse lkup_done for one cycle with the flags, then go to IDLE.
  - hit=1 with expired=1 is reported as is; the consumer decides.
  - Miss reports hit=0, expired=0, tid=0.
- First match wins; later candidates are not read.
- Acks arriving in IDLE/SCAN/DONE are ignored. Only one lookup is outstanding.
- Reset (including mid-lookup): the state goes to IDLE, all latches clear, no lkup_done is issued for the aborted request, and any in-flight ack is discarded.

## Timing
- Reset values:
  - lkup_ready=1.
  - All rd strobes, lkup_done, lkup_hit, lkup_expired = 0.
  - lkup_tid and all raddr = 0.
- rd strobes are registered one-cycle pulses. raddr is valid in the same cycle.
- The key and etime stores ack exactly 1 cycle after rd.
- Latency from accept (cycle T), with hash acks returning at cycle T+1+L:
  - Hash rd at T+1.
  - If the first candidate matches: key rd at T+L+3, ack at T+L+4, lkup_done at T+L+5.
  - Each extra mismatching candidate adds 2 cycles.
  - A miss with no valid slots gives lkup_done at T+L+4.
- lkup_ready returns high the cycle after lkup_done, so back-to-back accepts are possible at done+1.

## Configuration
- TOPIC_LOOKUP_ETIME_CHECK_EN defined: topic_etime_rd is pulsed with each topic_key_rd, and lkup_expired is computed as above.
- Not defined:
  - topic_etime_rd and topic_etime_raddr are tied to 0, and etime_ack/rdata are unused.
  - lkup_expired is constant 0.
  - Timing is unchanged.

## Test plan
- Key 0x1234 stored at ptr 5, bucket0 slot 2 valid, etime 100, cur_time 50. Required: hit=1, expired=0, tid=5, and exactly one key read.
- Same entry with cur_time 100. Required: hit=1, expired=1 (boundary equality). With the macro undefined: expired=0.
- Both buckets fully valid (ENTRIES=4) and none matching. Required: 8 key reads at ptrs in bucket0-then-bucket1 order, then hit=0, tid=0, done at T+L+19.
- Hash acks skewed: ack1 at T+2, ack0 at T+7. Required: no key read before T+8, correct result.
- Both buckets all-invalid. Required: zero key reads, miss done at T+L+4.
- rst asserted during KEY_WAIT. Required: outputs at reset values immediately, no lkup_done, the next request after release completes correctly.
